seq_run_ctrl: RTL and testbench
===============================

# seq_run_ctrl

Run controller for the sequence-detection datapath: sequences one complete pass of the LFSR pattern source through the sequence-detecting FSM and counts the detections. It seeds the LFSR, clears the FSM, paces LFSR/FSM stepping with a programmable prescaler, ends the run on the LFSR wrap indication, and latches a saturating detection count for the display path. It sits between top-level control (button/start logic) and the `lfsr`/`fsm` instances.

## Interface
- `WIDTH`, 16: width of detection counter and `result`
- `PRESCALE`, 1: clocks per LFSR/FSM step (≥1)
- `clk`  in  1  system clock, all state rises on posedge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  run request, sampled in IDLE only
- `abort`  in  1  cancel current run
- `max_tick`  in  1  LFSR wrap flag, high during last state of the sequence
- `det_pulse`  in  1  FSM detection output, one clock per detection
- `lfsr_load`  out  1  load seed into LFSR this clock
- `fsm_clr`  out  1  synchronous clear of the FSM this clock
- `step_en`  out  1  advance LFSR and FSM this clock
- `busy`  out  1  high in LOAD, RUN, DONE
- `done`  out  1  one-clock pulse when a run completes normally
- `result`  out  WIDTH  latched detection count of last completed run
- `result_valid`  out  1  `result` holds a completed, non-aborted run
- `overflow`  out  1  detection count saturated during last run

## Operation
- States: IDLE, LOAD, RUN, DONE.
- IDLE: `start`=1 and `abort`=0 → LOAD. `start` and `abort` both high → stay IDLE.
- LOAD (exactly one clock): `lfsr_load`=1, `fsm_clr`=1; internal count ← 0, sticky overflow flag ← 0, prescaler ← 0 → RUN.
- RUN: prescaler counts 0..PRESCALE-1; `step_en`=1 in the cycle prescaler = PRESCALE-1, then wraps to 0. With PRESCALE=1, `step_en`=1 every RUN cycle.
- RUN exit: the first cycle with `step_en`=1 and `max_tick`=1 → DONE. `max_tick` ignored when `step_en`=0.
- DONE (exactly one clock): no `step_en`; still counts `det_pulse` (covers FSM output one cycle after final step) → IDLE.
- DONE→IDLE edge: `result` ← count (including DONE-cycle pulse), `result_valid` ← 1, `overflow` ← sticky flag, `done` registered high for the first IDLE cycle only.
- Counting: `det_pulse` counted in RUN and DONE only; ignored in IDLE/LOAD. Saturating at 2^WIDTH-1; a pulse while at max sets sticky flag, count holds.
- `abort` in LOAD, RUN or DONE → IDLE next clock; no `done`; `result_valid` ← 0; `result`/`overflow` hold previous values.
- `start` outside IDLE is ignored (no queuing).
- `busy` decoded from state (combinational off the state register).

## Timing
- Reset (async, `rst_n`=0): state IDLE; all outputs 0, `result`=0; internal count and prescaler 0. Takes effect immediately, mid-run included; no `done` follows.
- `start` sampled at edge N (IDLE) → LOAD in cycle N+1 → RUN from N+2.
- First `step_en`: cycle N+1+PRESCALE.
- Run of S steps: DONE in cycle N+2+S·PRESCALE, `done`/`result_valid` visible in N+3+S·PRESCALE.
- Full 16-bit LFSR pass, PRESCALE=1: S = 65535 steps.
- Back-to-back: `start` held high in the `done` cycle starts the next run (LOAD next cycle).
- `lfsr_load`, `fsm_clr`, `step_en` mutually exclusive.

## Structure
- Package `seq_ctrl_pkg`: state encoding constants (IDLE=2'd0, LOAD=2'd1, RUN=2'd2, DONE=2'd3), shared with display/top logic that decodes `busy` status.
- Sub-module `step_prescaler` (params `PRESCALE`; ports `clk`, `rst_n`, `clr`, `en`, `tick`): clears on LOAD, enabled in RUN, `tick` drives `step_en`.
- Counter and FSM in the top of `seq_run_ctrl`.

## Test plan
- Reset: drop `rst_n` 3 cycles into RUN → all outputs 0 same cycle, IDLE after release, no `done`.
- PRESCALE=1: `start` pulse, 3 `det_pulse`s in RUN, `max_tick` with 5th `step_en` → exactly 5 `step_en`, `done` one cycle, `result`=3, `result_valid`=1, `overflow`=0.
- PRESCALE=4: `step_en` every 4th clock, first at LOAD+4; `det_pulse` in DONE cycle counted → `result` includes it.
- WIDTH=4: 17 `det_pulse`s in RUN → `result`=15, `overflow`=1; next run with 2 pulses → `result`=2, `overflow`=0.
- `abort` mid-RUN → IDLE next clock, `done` never asserted, `result_valid`=0, prior `result` unchanged; `start` during RUN ignored (no second LOAD).
- `start`+`abort` together in IDLE → stays IDLE; `start` held through `done` → LOAD the following cycle.

Source files
------------

// File: rtl/seq_ctrl_pkg.sv
// rtl/seq_ctrl_pkg.sv - shared state encoding for the sequence run controller
//
// Purpose: state encoding of the run controller, shared with the display and
// top-level logic that decodes the busy status from the state value.
// Ports: none (package).

package seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } run_state_t;

  // Every state other than IDLE belongs to an active run.
  function automatic logic state_is_busy(input run_state_t s);
    return (s != ST_IDLE);
  endfunction

endpackage

// File: rtl/seq_run_ctrl_prescaler.sv
// rtl/seq_run_ctrl_prescaler.sv - programmable step prescaler for the run controller
//
// Purpose: divides the system clock into LFSR/FSM step strobes.
// Ports:
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset
//   clr   in  synchronous clear of the phase counter
//   en    in  count enable
//   tick  out high in the enabled cycle where the counter sits at PRESCALE-1

module step_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  // Keep at least one counter bit so PRESCALE=1 still elaborates cleanly;
  // the counter then never leaves zero and tick follows en directly.
  localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] r_cnt;

  assign tick = en && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      if (tick) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_run_ctrl.sv
// rtl/seq_run_ctrl.sv - run controller sequencing one LFSR pass through the detector FSM
//
// Purpose: seeds the LFSR, clears the detector FSM, paces stepping through a
// prescaler, ends the run on the LFSR wrap flag and latches a saturating
// detection count for the display path.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, abort        run request (IDLE only) and run cancel
//   max_tick            LFSR wrap flag, qualified by step_en
//   det_pulse           detector FSM hit, one clock per detection
//   lfsr_load, fsm_clr  seed the LFSR / clear the FSM (LOAD cycle)
//   step_en             advance LFSR and FSM
//   busy                run in progress (LOAD, RUN, DONE)
//   done                one-clock pulse after a normally completed run
//   result              detection count of the last completed run
//   result_valid        result belongs to a completed, non-aborted run
//   overflow            detection count saturated during the last run

module seq_run_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             max_tick,
  input  logic             det_pulse,
  output logic             lfsr_load,
  output logic             fsm_clr,
  output logic             step_en,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             overflow
);

  run_state_t       r_state;
  logic [WIDTH-1:0] r_cnt;
  logic             r_ovf;
  logic             r_lfsr_load;
  logic             r_fsm_clr;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_result_valid;
  logic             r_overflow;

  logic             w_tick;
  logic             w_presc_clr;
  logic             w_presc_en;
  logic             w_count_en;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic             w_ovf_nxt;

  assign w_presc_clr = (r_state == ST_LOAD);
  assign w_presc_en  = (r_state == ST_RUN);

  step_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_presc_clr),
    .en    (w_presc_en),
    .tick  (w_tick)
  );

  // DONE still counts: the FSM reports a hit one clock after the step that
  // produced it, so the final step's detection lands in DONE.
  assign w_count_en = det_pulse && ((r_state == ST_RUN) || (r_state == ST_DONE));

  // Saturating count; a hit at full scale only raises the sticky flag.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_ovf_nxt = r_ovf;
    if (w_count_en) begin
      if (&r_cnt) begin
        w_ovf_nxt = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_ovf          <= 1'b0;
      r_lfsr_load    <= 1'b0;
      r_fsm_clr      <= 1'b0;
      r_done         <= 1'b0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_overflow     <= 1'b0;
    end else begin
      r_lfsr_load <= 1'b0;
      r_fsm_clr   <= 1'b0;
      r_done      <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (start && !abort) begin
            r_state     <= ST_LOAD;
            // Registered here so both strobes are high exactly in LOAD.
            r_lfsr_load <= 1'b1;
            r_fsm_clr   <= 1'b1;
          end
        end
        ST_LOAD: begin
          r_cnt <= '0;
          r_ovf <= 1'b0;
          if (abort) begin
            r_state        <= ST_IDLE;
            r_result_valid <= 1'b0;
          end else begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort) begin
            r_state        <= ST_IDLE;
            r_result_valid <= 1'b0;
          end else begin
            r_cnt <= w_cnt_nxt;
            r_ovf <= w_ovf_nxt;
            // The wrap flag only means something on a step cycle.
            if (w_tick && max_tick) begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          if (abort) begin
            r_result_valid <= 1'b0;
          end else begin
            r_cnt          <= w_cnt_nxt;
            r_ovf          <= w_ovf_nxt;
            r_result       <= w_cnt_nxt;
            r_overflow     <= w_ovf_nxt;
            r_result_valid <= 1'b1;
            r_done         <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign lfsr_load    = r_lfsr_load;
  assign fsm_clr      = r_fsm_clr;
  assign step_en      = w_tick;
  assign busy         = state_is_busy(r_state);
  assign done         = r_done;
  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign overflow     = r_overflow;

endmodule

// File: tb/tb_seq_run_ctrl.sv
// tb/tb_seq_run_ctrl.sv - self-checking bench for seq_run_ctrl against a timing-rule model

module tb_seq_run_ctrl;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst_n;

  logic start    [N];
  logic abort    [N];
  logic max_tick [N];
  logic det      [N];

  logic lfsr_load [N];
  logic fsm_clr   [N];
  logic step_en   [N];
  logic busy      [N];
  logic done      [N];
  logic rv        [N];
  logic ovf       [N];
  logic [15:0] res0;
  logic [15:0] res1;
  logic [3:0]  res2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_run_ctrl #(.WIDTH(16), .PRESCALE(1)) u_d0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]),
    .max_tick(max_tick[0]), .det_pulse(det[0]), .lfsr_load(lfsr_load[0]),
    .fsm_clr(fsm_clr[0]), .step_en(step_en[0]), .busy(busy[0]), .done(done[0]),
    .result(res0), .result_valid(rv[0]), .overflow(ovf[0])
  );

  seq_run_ctrl #(.WIDTH(16), .PRESCALE(4)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]),
    .max_tick(max_tick[1]), .det_pulse(det[1]), .lfsr_load(lfsr_load[1]),
    .fsm_clr(fsm_clr[1]), .step_en(step_en[1]), .busy(busy[1]), .done(done[1]),
    .result(res1), .result_valid(rv[1]), .overflow(ovf[1])
  );

  seq_run_ctrl #(.WIDTH(4), .PRESCALE(1)) u_d2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .abort(abort[2]),
    .max_tick(max_tick[2]), .det_pulse(det[2]), .lfsr_load(lfsr_load[2]),
    .fsm_clr(fsm_clr[2]), .step_en(step_en[2]), .busy(busy[2]), .done(done[2]),
    .result(res2), .result_valid(rv[2]), .overflow(ovf[2])
  );

  function automatic int pval(input int i);
    return (i == 1) ? 4 : 1;
  endfunction

  function automatic int wval(input int i);
    return (i == 2) ? 4 : 16;
  endfunction

  function automatic logic [31:0] get_res(input int i);
    case (i)
      0:       return {16'b0, res0};
      1:       return {16'b0, res1};
      default: return {28'b0, res2};
    endcase
  endfunction

  // Reference model: a run is described by its age in clocks since the LOAD
  // cycle (LOAD = age 0), the age at which DONE occurs (-1 until the wrap
  // step), and the raw, unsaturated number of counted detections.
  bit m_active [N];
  int m_age    [N];
  int m_end    [N];
  int m_cnt    [N];
  int m_steps  [N];
  int m_res    [N];
  bit m_rv     [N];
  bit m_ovf    [N];
  bit m_done   [N];
  int tgt      [N];

  function automatic bit exp_step(input int i);
    return m_active[i] && (m_age[i] >= 1) && (m_end[i] < 0) && ((m_age[i] % pval(i)) == 0);
  endfunction

  function automatic bit exp_load(input int i);
    return m_active[i] && (m_age[i] == 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_active[i] = 0; m_age[i] = 0; m_end[i] = -1; m_cnt[i] = 0;
      m_steps[i] = 0; m_res[i] = 0; m_rv[i] = 0; m_ovf[i] = 0; m_done[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < N; i++) begin
      bit st;
      int maxv;
      st = exp_step(i);
      maxv = (1 << wval(i)) - 1;
      m_done[i] = 0;
      if (!m_active[i]) begin
        if (start[i] && !abort[i]) begin
          m_active[i] = 1; m_age[i] = 0; m_end[i] = -1; m_cnt[i] = 0; m_steps[i] = 0;
        end
      end else if (abort[i]) begin
        m_active[i] = 0;
        m_rv[i] = 0;
      end else begin
        if (m_age[i] >= 1 && det[i]) m_cnt[i]++;
        if (m_end[i] >= 0) begin
          m_active[i] = 0;
          m_res[i] = (m_cnt[i] > maxv) ? maxv : m_cnt[i];
          m_ovf[i] = (m_cnt[i] > maxv);
          m_rv[i] = 1;
          m_done[i] = 1;
        end else if (st) begin
          m_steps[i]++;
          if (max_tick[i]) m_end[i] = m_age[i] + 1;
        end
        m_age[i]++;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < N; i++) begin
      check($sformatf("i%0d_lfsr_load", i), 32'(lfsr_load[i]), 32'(exp_load(i)));
      check($sformatf("i%0d_fsm_clr", i), 32'(fsm_clr[i]), 32'(exp_load(i)));
      check($sformatf("i%0d_step_en", i), 32'(step_en[i]), 32'(exp_step(i)));
      check($sformatf("i%0d_busy", i), 32'(busy[i]), 32'(m_active[i]));
      check($sformatf("i%0d_done", i), 32'(done[i]), 32'(m_done[i]));
      check($sformatf("i%0d_result", i), get_res(i), 32'(m_res[i]));
      check($sformatf("i%0d_result_valid", i), 32'(rv[i]), 32'(m_rv[i]));
      check($sformatf("i%0d_overflow", i), 32'(ovf[i]), 32'(m_ovf[i]));
    end
  endtask

  // Wrap flag: on a predicted step it is raised at the target step (or at
  // random); off step cycles it is random noise that must be ignored.
  task automatic drive_mt();
    for (int i = 0; i < N; i++) begin
      if (exp_step(i)) begin
        if (tgt[i] > 0) max_tick[i] = ((m_steps[i] + 1) == tgt[i]);
        else            max_tick[i] = ($urandom_range(0, 5) == 0);
      end else begin
        max_tick[i] = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic tick_cycle();
    drive_mt();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic run_one(input int i, input int nsteps, input int det_from, input int det_n,
                         input bit det_in_done, output int steps_seen, output int first_age,
                         output int loads_seen, output int dones_seen);
    int cyc;
    bit finished;
    steps_seen = 0; first_age = -1; loads_seen = 0; dones_seen = 0;
    cyc = 0; finished = 0;
    tgt[i] = nsteps;
    start[i] = 1; det[i] = 0;
    tick_cycle();
    if (lfsr_load[i]) loads_seen++;
    start[i] = 0;
    while (cyc < 4000 && !finished) begin
      if (m_active[i] && m_end[i] < 0)
        det[i] = (m_age[i] >= det_from) && (m_age[i] < det_from + det_n);
      else
        det[i] = m_active[i] && det_in_done;
      tick_cycle();
      cyc++;
      if (lfsr_load[i]) loads_seen++;
      if (step_en[i]) begin
        steps_seen++;
        if (first_age < 0) first_age = m_age[i];
      end
      if (done[i]) begin
        dones_seen++;
        finished = 1;
      end
    end
    det[i] = 0; tgt[i] = 0;
    if (!finished) check($sformatf("i%0d_run_timeout", i), 0, 1);
    tick_cycle();
    if (done[i]) dones_seen++;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, f, l, d, cnt;
    rst_n = 0;
    for (int i = 0; i < N; i++) begin
      start[i] = 0; abort[i] = 0; max_tick[i] = 0; det[i] = 0; tgt[i] = 0;
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare_all();
    rst_n = 1;
    tick_cycle();

    // PRESCALE=1: five steps, three hits, wrap on the fifth step.
    run_one(0, 5, 1, 3, 0, s, f, l, d);
    check("p1_steps", 32'(s), 5);
    check("p1_first_step_age", 32'(f), 1);
    check("p1_loads", 32'(l), 1);
    check("p1_done_pulses", 32'(d), 1);
    check("p1_result", get_res(0), 3);
    check("p1_result_valid", 32'(rv[0]), 1);
    check("p1_overflow", 32'(ovf[0]), 0);

    // PRESCALE=4: first step at LOAD+4, hit in the DONE cycle is counted.
    run_one(1, 3, 1, 2, 1, s, f, l, d);
    check("p4_steps", 32'(s), 3);
    check("p4_first_step_age", 32'(f), 4);
    check("p4_result", get_res(1), 3);
    check("p4_done_pulses", 32'(d), 1);

    // WIDTH=4: saturation then a clean follow-up run.
    run_one(2, 20, 1, 17, 0, s, f, l, d);
    check("w4_sat_result", get_res(2), 15);
    check("w4_sat_overflow", 32'(ovf[2]), 1);
    run_one(2, 3, 1, 2, 0, s, f, l, d);
    check("w4_next_result", get_res(2), 2);
    check("w4_next_overflow", 32'(ovf[2]), 0);
    check("w4_next_valid", 32'(rv[2]), 1);

    // Abort mid-RUN with start held during the run.
    tgt[0] = 100; l = 0; d = 0;
    start[0] = 1;
    tick_cycle();
    if (lfsr_load[0]) l++;
    for (int k = 0; k < 3; k++) begin
      tick_cycle();
      if (lfsr_load[0]) l++;
    end
    start[0] = 0; abort[0] = 1;
    tick_cycle();
    abort[0] = 0;
    check("abort_busy", 32'(busy[0]), 0);
    check("abort_valid", 32'(rv[0]), 0);
    check("abort_result_held", get_res(0), 3);
    check("abort_single_load", 32'(l), 1);
    for (int k = 0; k < 3; k++) begin
      tick_cycle();
      if (done[0]) d++;
    end
    check("abort_no_done", 32'(d), 0);

    // start and abort together in IDLE.
    start[0] = 1; abort[0] = 1;
    tick_cycle();
    start[0] = 0; abort[0] = 0;
    tick_cycle();
    check("start_abort_idle_busy", 32'(busy[0]), 0);
    check("start_abort_idle_load", 32'(lfsr_load[0]), 0);

    // start held through done: next LOAD directly after the done cycle.
    tgt[0] = 2; start[0] = 1; cnt = 0;
    tick_cycle();
    while (cnt < 100 && !done[0]) begin
      tick_cycle();
      cnt++;
    end
    check("b2b_done_seen", 32'(done[0]), 1);
    tick_cycle();
    check("b2b_reload", 32'(lfsr_load[0]), 1);
    start[0] = 0; abort[0] = 1;
    tick_cycle();
    abort[0] = 0; tgt[0] = 0;
    tick_cycle();

    // Asynchronous reset three cycles into RUN; instance 1 still holds a result.
    tgt[0] = 100; start[0] = 1;
    tick_cycle();
    start[0] = 0;
    for (int k = 0; k < 3; k++) tick_cycle();
    #2;
    rst_n = 0;
    #1;
    check("rst_busy", 32'(busy[0]), 0);
    check("rst_step_en", 32'(step_en[0]), 0);
    check("rst_result1", get_res(1), 0);
    check("rst_valid1", 32'(rv[1]), 0);
    model_reset();
    tgt[0] = 0;
    @(negedge clk);
    compare_all();
    rst_n = 1;
    d = 0;
    for (int k = 0; k < 4; k++) begin
      tick_cycle();
      if (done[0]) d++;
    end
    check("rst_no_done", 32'(d), 0);

    // Randomized traffic on all three instances.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        start[i] = ($urandom_range(0, 5) == 0);
        abort[i] = ($urandom_range(0, 39) == 0);
        det[i]   = ($urandom_range(0, 2) == 0);
      end
      tick_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
